mult_accum_stage: RTL and testbench
===================================

MULT_ACCUM_STAGE -- requirements
Module: mult_accum_stage

Interface
REQ-001 The block SHALL have parameter LANES, default 28, meaning number of parallel multiplier lanes.
REQ-002 The block SHALL have parameter WW, default 19, meaning signed two's-complement weight width.
REQ-003 The block SHALL have parameter PW, default 10, meaning unsigned pixel width.
REQ-004 The block SHALL have parameter OW, default 26, meaning signed output and accumulator width per lane.
REQ-005 The block SHALL have parameter SHIFT, default 3, meaning the arithmetic right shift applied to each full product.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port GlobalReset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port WeightX, input, LANES*WW bits: lane k occupies bits [WW*k+WW-1 : WW*k].
REQ-009 The block SHALL have port PixelX, input, LANES*PW bits: lane k occupies bits [PW*k+PW-1 : PW*k].
REQ-010 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_acc (input, 1) and in_last (input, 1): input handshake, accumulate-group request and group end.
REQ-011 The block SHALL have port Output_syn, output, LANES*OW bits: lane k occupies bits [OW*k+OW-1 : OW*k].
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_sat (output, 1): output handshake and a flag that any lane saturated.

Function
REQ-013 A beat SHALL transfer when in_valid and in_ready are both 1 on a rising clk edge; an output SHALL transfer when out_valid and out_ready are both 1.
REQ-014 Pipeline enable SHALL be (!out_valid || out_ready); in_ready SHALL equal enable, combinationally.
REQ-015 Stages SHALL be S1 (input register), S2 (multiply, shift, saturate) and S3 (accumulate/output register); all stages hold when enable is 0.
REQ-016 Each lane's product SHALL be signed weight times zero-extended pixel at full width WW+PW+1, arithmetic right-shifted by SHIFT (truncation toward minus infinity), then saturated to OW-bit signed.
REQ-017 The state machine SHALL have states SINGLE and ACCUM, decided at S3 on each valid beat.
REQ-018 In SINGLE, a beat with in_acc=0 SHALL produce out_valid with Output_syn equal to the saturated products; latency SHALL be 3 cycles from transfer to out_valid with no stall.
REQ-019 In SINGLE, a beat with in_acc=1 and in_last=0 SHALL load the accumulators with its products, produce no output, and move the FSM to ACCUM.
REQ-020 In SINGLE, a beat with in_acc=1 and in_last=1 SHALL behave as a one-beat group: output the products and stay in SINGLE.
REQ-021 In ACCUM, every beat SHALL add its products to the accumulators with signed saturation at OW bits; in_acc is ignored.
REQ-022 In ACCUM, a beat with in_last=1 SHALL output the final sums and return the FSM to SINGLE.
REQ-023 in_last SHALL be ignored on beats with in_acc=0 while in SINGLE.
REQ-024 out_sat SHALL be 1 with an output if any lane saturated in the multiply or in any accumulate step of that output's group; it is cleared at each group start.
REQ-025 Output_syn and out_sat SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 GlobalReset=1 SHALL asynchronously clear all pipeline registers, valid bits, accumulators and out_sat, and force the FSM to SINGLE.
REQ-027 Under reset, Output_syn SHALL be 0, out_valid 0 and out_sat 0; in_ready SHALL be 1 after reset deasserts.
REQ-028 Reset during an ACCUM group SHALL discard the partial sums; no output SHALL be produced for that group.

Structure
REQ-029 A shared package SHALL hold the default values for LANES, WW, PW, OW and SHIFT, and the FSM state encoding.
REQ-030 A per-lane sub-module mac_lane SHALL hold the S2 multiply/shift/saturate logic and the S3 accumulator, and SHALL be instantiated LANES times by a generate loop.

Verification
REQ-031 Single beat, lane 0 weight 1000, pixel 512, in_acc=0 -> out_valid after 3 cycles, lane 0 output 64000, out_sat=0.
REQ-032 Weight -262144, pixel 1023 -> lane output -33521664 (exact, in range), out_sat=0; with OW=24 the output saturates to -8388608 and out_sat=1.
REQ-033 Four-beat group, in_acc=1, weight 8, pixel 100 on all lanes, in_last on beat 4 -> exactly one output, each lane 400.
REQ-034 out_ready held 0 for 5 cycles with a back-to-back stream -> in_ready=0, output held stable, no beat lost or duplicated; order is preserved when out_ready rises.
REQ-035 GlobalReset pulsed after beat 2 of a 4-beat group -> no output; the next single beat outputs its own product only.
REQ-036 Random regression with LANES=4, OW=20 against a reference model -> all lanes match, including saturation.

Source files
------------

// File: rtl/mult_accum_stage_pkg.sv
// Shared defaults and FSM encoding for the multiply/accumulate stage.
package mult_accum_stage_pkg;

  localparam int LANES_DEF = 28;
  localparam int WW_DEF    = 19;
  localparam int PW_DEF    = 10;
  localparam int OW_DEF    = 26;
  localparam int SHIFT_DEF = 3;

  // Group state held at the accumulate stage
  localparam logic [0:0] ST_SINGLE = 1'b0;
  localparam logic [0:0] ST_ACCUM  = 1'b1;

endpackage

// File: rtl/mac_lane.sv
// One lane: signed weight x unsigned pixel, shift, saturate (S2), then
// an accumulator register (S3) that either loads or saturating-adds.
module mac_lane
  import mult_accum_stage_pkg::*;
#(
  parameter int WW    = WW_DEF,
  parameter int PW    = PW_DEF,
  parameter int OW    = OW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [WW-1:0] weight,
  input  logic [PW-1:0] pixel,
  input  logic          load,
  input  logic          add,
  output logic [OW-1:0] acc,
  output logic          prod_sat,
  output logic          acc_sat
);

  localparam int PRODW = WW + PW + 1;
  // Wide enough to hold either the shifted product or the OW-bit bounds.
  localparam int XW    = PRODW + OW + 1;
  localparam logic signed [XW-1:0] MAXV = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [PRODW-1:0] full_prod;
  logic signed [PRODW-1:0] shifted;
  logic signed [XW-1:0]    ext;
  logic [OW-1:0]           prod_val;
  logic                    prod_ovf;
  logic [OW-1:0]           prod_reg;
  logic                    prod_sat_reg;
  logic [OW:0]             sum;
  logic [OW-1:0]           sum_val;
  logic                    sum_ovf;
  logic [OW-1:0]           acc_reg;

  // Full-precision product, floor shift, clamp to the OW-bit signed range
  always_comb begin
    full_prod = PRODW'($signed(weight)) * PRODW'($signed({1'b0, pixel}));
    shifted   = full_prod >>> SHIFT;
    ext       = XW'(shifted);
    prod_ovf  = 1'b0;
    prod_val  = ext[OW-1:0];
    if (ext > MAXV) begin
      prod_ovf = 1'b1;
      prod_val = MAXV[OW-1:0];
    end else if (ext < MINV) begin
      prod_ovf = 1'b1;
      prod_val = MINV[OW-1:0];
    end
  end

  // S2 register: saturated product and its overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg     <= '0;
      prod_sat_reg <= 1'b0;
    end else if (en) begin
      prod_reg     <= prod_val;
      prod_sat_reg <= prod_ovf;
    end
  end

  // Saturating add of the staged product into the running sum
  always_comb begin
    sum     = {acc_reg[OW-1], acc_reg} + {prod_reg[OW-1], prod_reg};
    sum_ovf = sum[OW] ^ sum[OW-1];
    sum_val = sum[OW-1:0];
    if (sum_ovf) begin
      sum_val = sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  // S3 accumulator: load starts a group (or a single result), add extends it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      if (load) begin
        acc_reg <= prod_reg;
      end else if (add) begin
        acc_reg <= sum_val;
      end
    end
  end

  assign acc      = acc_reg;
  assign prod_sat = prod_sat_reg;
  assign acc_sat  = sum_ovf;

endmodule

// File: rtl/mult_accum_stage.sv
// Three-stage multiply/accumulate pipeline with elastic output handshake.
// S1 registers the beat, S2 multiplies per lane, S3 accumulates or emits.
module mult_accum_stage
  import mult_accum_stage_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WW    = WW_DEF,
  parameter int PW    = PW_DEF,
  parameter int OW    = OW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic [LANES*WW-1:0] WeightX,
  input  logic [LANES*PW-1:0] PixelX,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_acc,
  input  logic                in_last,
  output logic [LANES*OW-1:0] Output_syn,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sat
);

  logic                enable;
  logic [LANES*WW-1:0] weight_reg;
  logic [LANES*PW-1:0] pixel_reg;
  logic                s1_valid;
  logic                s1_acc;
  logic                s1_last;
  logic                s2_valid;
  logic                s2_acc;
  logic                s2_last;
  logic [0:0]          state_reg;
  logic [0:0]          state_next;
  logic                out_valid_reg;
  logic                out_valid_next;
  logic                sat_reg;
  logic                sat_next;
  logic                lane_load;
  logic                lane_add;
  logic [LANES-1:0]    prod_sat_vec;
  logic [LANES-1:0]    acc_sat_vec;

  // Whole pipe advances unless a finished result is waiting to be taken
  assign enable   = !out_valid_reg || out_ready;
  assign in_ready = enable;

  // S1: capture the beat and its control bits
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      weight_reg <= '0;
      pixel_reg  <= '0;
      s1_valid   <= 1'b0;
      s1_acc     <= 1'b0;
      s1_last    <= 1'b0;
    end else if (enable) begin
      weight_reg <= WeightX;
      pixel_reg  <= PixelX;
      s1_valid   <= in_valid;
      s1_acc     <= in_acc;
      s1_last    <= in_last;
    end
  end

  // S2 control: follows the lane products through the multiply stage
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      s2_valid <= 1'b0;
      s2_acc   <= 1'b0;
      s2_last  <= 1'b0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      s2_acc   <= s1_acc;
      s2_last  <= s1_last;
    end
  end

  // Every beat in SINGLE reloads the accumulators; in ACCUM it adds
  assign lane_load = s2_valid && (state_reg == ST_SINGLE);
  assign lane_add  = s2_valid && (state_reg == ST_ACCUM);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane #(
        .WW   (WW),
        .PW   (PW),
        .OW   (OW),
        .SHIFT(SHIFT)
      ) u_lane (
        .clk     (clk),
        .rst     (GlobalReset),
        .en      (enable),
        .weight  (weight_reg[WW*gi +: WW]),
        .pixel   (pixel_reg[PW*gi +: PW]),
        .load    (lane_load),
        .add     (lane_add),
        .acc     (Output_syn[OW*gi +: OW]),
        .prod_sat(prod_sat_vec[gi]),
        .acc_sat (acc_sat_vec[gi])
      );
    end
  endgenerate

  // Group FSM: decide emit/continue and fold saturation into the group flag
  always_comb begin
    state_next     = state_reg;
    out_valid_next = 1'b0;
    sat_next       = sat_reg;
    if (s2_valid) begin
      if (state_reg == ST_SINGLE) begin
        sat_next = |prod_sat_vec;
        if (s2_acc && !s2_last) begin
          state_next = ST_ACCUM;
        end else begin
          out_valid_next = 1'b1;
        end
      end else begin
        sat_next = sat_reg | (|prod_sat_vec) | (|acc_sat_vec);
        if (s2_last) begin
          state_next     = ST_SINGLE;
          out_valid_next = 1'b1;
        end
      end
    end
  end

  // S3 control registers: FSM state, output valid and saturation flag
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_reg     <= ST_SINGLE;
      out_valid_reg <= 1'b0;
      sat_reg       <= 1'b0;
    end else if (enable) begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      sat_reg       <= sat_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sat   = sat_reg;

endmodule

// File: tb/tb_mult_accum_stage.sv
// Bench: three 4-lane instances (OW = 26, 24, 20) share one stimulus;
// a group-level reference model feeds a scoreboard checked every negedge.
module tb_mult_accum_stage;

  localparam int L  = 4;
  localparam int WW = 19;
  localparam int PW = 10;
  localparam int SH = 3;

  logic clk = 1'b0;
  logic GlobalReset = 1'b1;
  logic [L*WW-1:0] WeightX = '0;
  logic [L*PW-1:0] PixelX = '0;
  logic in_valid = 1'b0;
  logic in_acc = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic ir_a, ir_b, ir_c;
  logic ov_a, ov_b, ov_c;
  logic sat_a, sat_b, sat_c;
  logic [L*26-1:0] out_a;
  logic [L*24-1:0] out_b;
  logic [L*20-1:0] out_c;
  logic in_ready;
  bit rand_mode = 1'b0;

  int total = 0;
  int bad = 0;
  int n_out = 0;

  typedef struct packed {
    logic [2:0][3:0][63:0] v;
    logic [2:0]            s;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  bit     grp[3];
  bit     gsat[3];
  longint accm[3][4];

  always #5 clk = ~clk;
  assign in_ready = ir_a;

  mult_accum_stage #(.LANES(L), .OW(26)) dut_a (
    .clk(clk), .GlobalReset(GlobalReset), .WeightX(WeightX), .PixelX(PixelX),
    .in_valid(in_valid), .in_ready(ir_a), .in_acc(in_acc), .in_last(in_last),
    .Output_syn(out_a), .out_valid(ov_a), .out_ready(out_ready), .out_sat(sat_a));

  mult_accum_stage #(.LANES(L), .OW(24)) dut_b (
    .clk(clk), .GlobalReset(GlobalReset), .WeightX(WeightX), .PixelX(PixelX),
    .in_valid(in_valid), .in_ready(ir_b), .in_acc(in_acc), .in_last(in_last),
    .Output_syn(out_b), .out_valid(ov_b), .out_ready(out_ready), .out_sat(sat_b));

  mult_accum_stage #(.LANES(L), .OW(20)) dut_c (
    .clk(clk), .GlobalReset(GlobalReset), .WeightX(WeightX), .PixelX(PixelX),
    .in_valid(in_valid), .in_ready(ir_c), .in_acc(in_acc), .in_last(in_last),
    .Output_syn(out_c), .out_valid(ov_c), .out_ready(out_ready), .out_sat(sat_c));

  function automatic int ow_of(input int i);
    return (i == 0) ? 26 : (i == 1) ? 24 : 20;
  endfunction

  function automatic longint satv(input longint v, input int ow, output bit s);
    longint mx = (longint'(1) <<< (ow - 1)) - 1;
    longint mn = -(longint'(1) <<< (ow - 1));
    s = 1'b0;
    if (v > mx) begin s = 1'b1; return mx; end
    if (v < mn) begin s = 1'b1; return mn; end
    return v;
  endfunction

  function automatic longint lane_of(input logic [103:0] bus, input int ow, input int k);
    logic [103:0] sh;
    longint r;
    sh = bus >> (k * ow);
    r  = longint'(sh[63:0]) & ((longint'(1) <<< ow) - 1);
    if (r >= (longint'(1) <<< (ow - 1))) r = r - (longint'(1) <<< ow);
    return r;
  endfunction

  function automatic logic [103:0] bus_of(input int i);
    if (i == 0) return out_a;
    if (i == 1) return {8'b0, out_b};
    return {24'b0, out_c};
  endfunction

  function automatic logic sat_of(input int i);
    return (i == 0) ? sat_a : (i == 1) ? sat_b : sat_c;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: apply one accepted beat to each instance's group state
  task automatic model_beat();
    exp_t ne;
    bit push;
    ne = '0;
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit ps;
      bit s;
      longint prs[4];
      ps = 1'b0;
      for (int k = 0; k < L; k++) begin
        longint w, p;
        w = longint'($signed(WeightX[k*WW +: WW]));
        p = longint'(PixelX[k*PW +: PW]);
        prs[k] = satv((w * p) >>> SH, ow_of(i), s);
        ps |= s;
      end
      if (!grp[i]) begin
        if (in_acc && !in_last) begin
          grp[i] = 1'b1;
          gsat[i] = ps;
          for (int k = 0; k < L; k++) accm[i][k] = prs[k];
        end else begin
          push = 1'b1;
          ne.s[i] = ps;
          for (int k = 0; k < L; k++) ne.v[i][k] = prs[k];
        end
      end else begin
        gsat[i] |= ps;
        for (int k = 0; k < L; k++) begin
          accm[i][k] = satv(accm[i][k] + prs[k], ow_of(i), s);
          gsat[i] |= s;
        end
        if (in_last) begin
          push = 1'b1;
          grp[i] = 1'b0;
          ne.s[i] = gsat[i];
          for (int k = 0; k < L; k++) ne.v[i][k] = accm[i][k];
        end
      end
    end
    if (push) q.push_back(ne);
  endtask

  // Scoreboard: compare pending outputs every cycle they are valid
  always @(negedge clk) begin
    if (GlobalReset) begin
      q.delete();
      for (int i = 0; i < 3; i++) grp[i] = 1'b0;
    end else begin
      if (ov_a || ov_b || ov_c) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_spurious_output got=valid want=none t=%0t", $time);
        end else begin
          e = q[0];
          chk("sb_valid_b", longint'(ov_b), 1);
          chk("sb_valid_c", longint'(ov_c), 1);
          for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < L; k++)
              chk($sformatf("sb_lane i%0d k%0d", i, k),
                  lane_of(bus_of(i), ow_of(i), k), longint'($signed(e.v[i][k])));
            chk($sformatf("sb_sat i%0d", i), longint'(sat_of(i)), longint'(e.s[i]));
          end
          if (out_ready) begin
            n_out++;
            $display("out %0d lane0=%0d sat=%0d", n_out, lane_of(bus_of(0), 26, 0), sat_a);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) model_beat();
    end
  end

  task automatic set_lane(input int k, input int w, input int p);
    WeightX[k*WW +: WW] = WW'(w);
    PixelX[k*PW +: PW]  = PW'(p);
  endtask

  task automatic set_all(input int w, input int p);
    for (int k = 0; k < L; k++) set_lane(k, w, p);
  endtask

  // Present a beat (called at posedge+1); returns at posedge+1 after transfer
  task automatic send(input bit a, input bit l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_acc   = a;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      if (rand_mode) out_ready = ($urandom_range(0, 1) == 1);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_acc   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!ov_a && n < 20) begin @(posedge clk); #1; n++; end
    chk(name, longint'(ov_a), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", longint'(ov_a), 0);
    chk("rst_out_sat", longint'(sat_a), 0);
    chk("rst_output", longint'(out_a[63:0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    GlobalReset = 1'b0;
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    // Single beat, 3-edge latency, floor shift on negative products
    set_lane(0, 1000, 512);
    set_lane(1, -5, 3);
    set_lane(2, 7, 255);
    set_lane(3, -1, 1);
    send(1'b0, 1'b0);
    idle();
    chk("lat_edge1", longint'(ov_a), 0);
    @(posedge clk); #1;
    chk("lat_edge2", longint'(ov_a), 0);
    @(posedge clk); #1;
    chk("lat_edge3", longint'(ov_a), 1);
    chk("single_lane0", lane_of(bus_of(0), 26, 0), 64000);
    chk("single_lane1", lane_of(bus_of(0), 26, 1), -2);
    chk("single_lane2", lane_of(bus_of(0), 26, 2), 223);
    chk("single_lane3", lane_of(bus_of(0), 26, 3), -1);
    chk("single_sat", longint'(sat_a), 0);
    @(posedge clk); #1;

    // Extreme product: exact at OW=26, clamps at OW=24 and OW=20
    set_all(0, 0);
    set_lane(0, -262144, 1023);
    send(1'b0, 1'b0);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("big_a_lane0", lane_of(bus_of(0), 26, 0), -33521664);
    chk("big_a_sat", longint'(sat_a), 0);
    chk("big_b_lane0", lane_of(bus_of(1), 24, 0), -8388608);
    chk("big_b_sat", longint'(sat_b), 1);
    chk("big_c_lane0", lane_of(bus_of(2), 20, 0), -524288);
    chk("big_c_sat", longint'(sat_c), 1);
    @(posedge clk); #1;

    // Four-beat group: one output of 4 x 100 per lane
    set_all(8, 100);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    idle();
    wait_out("grp_valid");
    for (int k = 0; k < L; k++) chk("grp_lane", lane_of(bus_of(0), 26, k), 400);
    @(posedge clk); #1;
    chk("grp_single_output", longint'(ov_a), 0);

    // Back-to-back stream with a 5-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < L; k++) set_lane(k, i * 100 + k - 300, 8 * i + k);
          send(1'b0, 1'b0);
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", longint'(in_ready), 0);
        chk("stall_in_ready_b", longint'(ir_b), 0);
        chk("stall_in_ready_c", longint'(ir_c), 0);
        chk("stall_out_valid", longint'(ov_a), 1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("stream_drained", longint'(q.size()), 0);

    // Reset in the middle of a group discards the partial sums
    set_all(50, 80);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    GlobalReset = 1'b1;
    #1;
    chk("midrst_lane0", lane_of(bus_of(0), 26, 0), 0);
    chk("midrst_out_valid", longint'(ov_a), 0);
    @(negedge clk); #2;
    GlobalReset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", longint'(in_ready), 1);
    set_all(3, 16);
    send(1'b0, 1'b0);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("postrst_valid", longint'(ov_a), 1);
    chk("postrst_lane0", lane_of(bus_of(0), 26, 0), 6);
    chk("postrst_sat", longint'(sat_a), 0);
    @(posedge clk); #1;

    // Randomised mix of singles, groups and output back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < L; k++)
        set_lane(k, int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 1023)));
      out_ready = ($urandom_range(0, 3) != 0);
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    idle();
    rand_mode = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_drained", longint'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
